st7735_spi_tx: RTL and testbench
================================

# st7735_spi_tx

Buffered SPI byte transmitter that drives the ST7735 panel pins (CS, DC, MOSI, LCD_CLK). It sits directly downstream of the ST7735 command/init sequencer, which pushes {DC, byte} pairs through a valid/ready handshake. The block queues them in a small FIFO and serializes them MSB-first in SPI mode 0. Consecutive bytes share one CS frame, with no idle clocks between them.

## Interface
Parameters:
- CLOCK_SPEED_MHZ, 12, SYSTEM_CLK frequency; informational only, no logic depends on it.
- SPI_DIV, 2, LCD_CLK half-period in SYSTEM_CLK cycles; legal range 1..255.
- FIFO_DEPTH, 4, number of queued {DC, byte} entries; power of two, ≥2.

Ports:
- SYSTEM_CLK  in  1  the only clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- TX_DATA  in  8  byte to transmit.
- TX_DC  in  1  DC level for this byte (0 = command, 1 = data).
- TX_VALID  in  1  TX_DATA/TX_DC are valid.
- TX_READY  out  1  FIFO can accept an entry; equals !full, combinational.
- BUSY  out  1  FIFO non-empty or FSM not in IDLE.
- CS  out  1  panel chip select, active low.
- DC  out  1  panel data/command select.
- MOSI  out  1  serial data, MSB first.
- LCD_CLK  out  1  serial clock; idles low, panel samples on the rising edge.

## Operation
- Push occurs when TX_VALID && TX_READY at a rising edge. Entries are stored as {TX_DC, TX_DATA}. Order is strictly FIFO.
- Pop occurs when the FSM loads a byte (entry into LOW for bit 7).
- Push and pop in the same cycle leave the count unchanged.
- A push is never accepted while full; TX_VALID held while full has no effect.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP. A bit counter runs 7..0; a phase counter runs 0..SPI_DIV-1.
- IDLE: CS=1, LCD_CLK=0.
  - FIFO non-empty → pop, CS=0, DC=entry DC, MOSI=entry bit 7, bit=7 → LOW.
- LOW: LCD_CLK=0 for SPI_DIV cycles → HIGH.
- HIGH: LCD_CLK=1 for SPI_DIV cycles, then:
  - bit>0 → bit--, MOSI=next bit → LOW.
  - bit==0 and FIFO non-empty → pop, update DC and MOSI, bit=7 → LOW. CS stays 0 and no extra cycles are inserted.
  - bit==0 and FIFO empty → HOLD.
- HOLD: LCD_CLK=0, CS=0 for SPI_DIV cycles → GAP, driving CS=1.
- GAP: CS=1 for SPI_DIV cycles → IDLE. This guarantees the minimum CS-high time; entries pushed during HOLD or GAP wait.
- DC and MOSI change only on entry to LOW, so they are stable for SPI_DIV cycles before every LCD_CLK rise and for the whole high phase.
- RST (asynchronous) takes effect immediately, even mid-byte:
  - FIFO is flushed and the FSM goes to IDLE.
  - The partial byte is abandoned.
  - Outputs take their reset values.

## Timing
- Reset values: CS=1, LCD_CLK=0, MOSI=0, DC=0, BUSY=0, TX_READY=1.
- Latency: if a push is accepted at edge N with the FSM in IDLE, CS falls and DC/MOSI are valid at edge N+1.
- The first LCD_CLK rise comes SPI_DIV cycles after CS falls.
- Each byte occupies 16·SPI_DIV cycles, measured from entry into LOW for bit 7 to the end of HIGH for bit 0.
- A frame of k back-to-back bytes holds CS low for 16·SPI_DIV·k + SPI_DIV cycles.
- CS high between frames lasts at least SPI_DIV cycles.
- BUSY falls on the cycle after GAP completes with the FIFO empty.
- Throughput is 1 byte per 16·SPI_DIV cycles; an upstream source that keeps the FIFO non-empty incurs no CS gaps.
- With SPI_DIV=1, LCD_CLK = SYSTEM_CLK/2.

## Test plan
- Reset: hold RST 3 cycles → CS=1, LCD_CLK=0, MOSI=0, DC=0, BUSY=0, TX_READY=1.
- Single command, SPI_DIV=2: push 0x2A with DC=0.
  - CS low one cycle after accept, for 34 cycles.
  - Exactly 8 LCD_CLK rises, sampling MOSI = 0,0,1,0,1,0,1,0.
  - DC=0 throughout; BUSY clears 2 cycles after CS rises.
- Back-to-back frame: push 0x2A/DC=0, 0x00/DC=1, 0x7F/DC=1 on consecutive cycles.
  - CS stays low for 98 cycles with 24 rises.
  - DC goes to 1 exactly 2 cycles before rise 9.
  - Sampled bytes are 0x2A, 0x00, 0x7F.
- Backpressure: hold TX_VALID with 10 incrementing bytes (0x10..0x19).
  - TX_READY drops whenever the FIFO holds 4 entries.
  - All 10 bytes are sent in order in one CS frame; none lost or duplicated.
- Reset mid-byte: assert RST during the high phase of bit 3 of 0x55, with 2 entries queued.
  - Immediately CS=1, LCD_CLK=0, BUSY=0.
  - After release, push 0xA5 → only 0xA5 is transmitted.
- Frame gap: push 0x11, then push 0x22 during HOLD of 0x11 → CS high for ≥2 cycles between two separate frames; each frame has 8 rises.

Source files
------------

// File: rtl/st7735_spi_tx.sv
// Buffered SPI mode-0 byte transmitter for the ST7735 panel.
// Queues {DC, byte} entries and shifts them out MSB-first, chaining queued bytes in one CS frame.
module st7735_spi_tx #(
  parameter int unsigned CLOCK_SPEED_MHZ = 12,
  parameter int unsigned SPI_DIV         = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       SYSTEM_CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_DC,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       CS,
  output logic       DC,
  output logic       MOSI,
  output logic       LCD_CLK
);

  localparam int unsigned PW = 8;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 9;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SPI_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // Reject illegal parameterisations at elaboration time.
  if (SPI_DIV < 1 || SPI_DIV > 255 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLOCK_SPEED_MHZ == 0) begin : g_param_check
    $error("st7735_spi_tx: illegal parameter value");
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, full, empty;
  logic [EW-1:0] head;

  logic [2:0]    state, state_next;
  logic [PW-1:0] phase, phase_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [6:0]    shift, shift_next;
  logic          cs_next, dc_next, mosi_next, clk_next;
  logic          load;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = TX_VALID && !full;
  assign TX_READY = !full;
  assign BUSY     = !empty || (state != S_IDLE);
  assign head     = mem[rd_ptr];
  assign pop      = load;

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge SYSTEM_CLK) begin
    if (push) mem[wr_ptr] <= {TX_DC, TX_DATA};
  end

  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      CS      <= 1'b1;
      DC      <= 1'b0;
      MOSI    <= 1'b0;
      LCD_CLK <= 1'b0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      CS      <= cs_next;
      DC      <= dc_next;
      MOSI    <= mosi_next;
      LCD_CLK <= clk_next;
    end
  end

  // Next-state and output logic; DC/MOSI only move when entering LOW.
  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_cnt;
    shift_next = shift;
    cs_next    = CS;
    dc_next    = DC;
    mosi_next  = MOSI;
    clk_next   = LCD_CLK;
    load       = 1'b0;

    case (state)
      S_IDLE: begin
        cs_next  = 1'b1;
        clk_next = 1'b0;
        if (!empty) begin
          load       = 1'b1;
          phase_next = '0;
          state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (phase == PHASE_LAST) begin
          phase_next = '0;
          clk_next   = 1'b1;
          state_next = S_HIGH;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      S_HIGH: begin
        if (phase == PHASE_LAST) begin
          phase_next = '0;
          clk_next   = 1'b0;
          if (bit_cnt != 3'd0) begin
            bit_next   = bit_cnt - 3'd1;
            mosi_next  = shift[6];
            shift_next = {shift[5:0], 1'b0};
            state_next = S_LOW;
          end else if (!empty) begin
            load       = 1'b1;
            state_next = S_LOW;
          end else begin
            state_next = S_HOLD;
          end
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      S_HOLD: begin
        if (phase == PHASE_LAST) begin
          phase_next = '0;
          cs_next    = 1'b1;
          state_next = S_GAP;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      S_GAP: begin
        if (phase == PHASE_LAST) begin
          phase_next = '0;
          state_next = S_IDLE;
        end else begin
          phase_next = phase + PW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        phase_next = '0;
        cs_next    = 1'b1;
        clk_next   = 1'b0;
      end
    endcase

    if (load) begin
      cs_next    = 1'b0;
      dc_next    = head[8];
      mosi_next  = head[7];
      shift_next = head[6:0];
      bit_next   = 3'd7;
    end
  end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// Self-checking bench for st7735_spi_tx: directed scenarios plus random traffic,
// checked against a queue/occupancy reference model of the panel-side waveform.
module tb_st7735_spi_tx;

  localparam int unsigned DIV   = 2;
  localparam int unsigned DEPTH = 4;

  logic       SYSTEM_CLK;
  logic       RST;
  logic [7:0] TX_DATA;
  logic       TX_DC;
  logic       TX_VALID;
  logic       TX_READY;
  logic       BUSY;
  logic       CS;
  logic       DC;
  logic       MOSI;
  logic       LCD_CLK;

  st7735_spi_tx #(
    .CLOCK_SPEED_MHZ(12),
    .SPI_DIV        (DIV),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .SYSTEM_CLK(SYSTEM_CLK),
    .RST       (RST),
    .TX_DATA   (TX_DATA),
    .TX_DC     (TX_DC),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .CS        (CS),
    .DC        (DC),
    .MOSI      (MOSI),
    .LCD_CLK   (LCD_CLK)
  );

  initial SYSTEM_CLK = 1'b0;
  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state, updated once per cycle on the falling edge.
  logic [8:0] exp_q[$];
  int   occ, cyc, nbits, frame_rises, rise_total, low_cnt, hi_cnt, since_rise;
  int   rise_cyc, busy_lag, last_gap, last_len, last_rises, frames_done, bytes_rx;
  int   saw_full, mosi_stable, dc_stable;
  logic push_pend, prev_cs, prev_clk, prev_mosi, prev_dc, prev_busy, last_rise_dc;
  logic rise, fall, cs_fall, cs_rise, pop;
  logic [7:0] acc, last_byte;

  initial begin
    cyc = 0; rise_total = 0; frames_done = 0; bytes_rx = 0; saw_full = 0;
    busy_lag = 0; last_gap = 0; last_len = 0; last_rises = 0; rise_cyc = 0;
    last_byte = '0;
  end

  always @(negedge SYSTEM_CLK) begin
    cyc++;
    if (RST) begin
      exp_q.delete();
      occ = 0; push_pend = 1'b0; acc = '0; nbits = 0; frame_rises = 0;
      low_cnt = 0; hi_cnt = 1000; since_rise = 1000;
      mosi_stable = 1000; dc_stable = 1000;
      prev_cs = 1'b1; prev_clk = 1'b0; prev_mosi = 1'b0; prev_dc = 1'b0;
      prev_busy = 1'b0; last_rise_dc = 1'b0;
    end else begin
      rise    = LCD_CLK && !prev_clk;
      fall    = !LCD_CLK && prev_clk;
      cs_fall = !CS && prev_cs;
      cs_rise = CS && !prev_cs;
      mosi_stable = (MOSI !== prev_mosi) ? 0 : mosi_stable + 1;
      dc_stable   = (DC !== prev_dc) ? 0 : dc_stable + 1;

      // A byte leaves the queue when a frame opens or when a finished byte chains into the next.
      pop = cs_fall || (fall && !CS && (frame_rises % 8 == 0) && occ > 0);
      if (cs_fall) chk("pop_from_empty", 32'(occ > 0), 32'd1);
      occ = occ + (push_pend ? 1 : 0) - (pop ? 1 : 0);
      chk("tx_ready", 32'(TX_READY), 32'(occ < int'(DEPTH)));
      if (!TX_READY) saw_full++;

      if (cs_rise) begin since_rise = 0; rise_cyc = cyc; end
      else if (CS) since_rise++;
      chk("busy", 32'(BUSY), 32'((occ > 0) || !CS || since_rise < int'(DIV)));
      if (prev_busy && !BUSY) busy_lag = cyc - rise_cyc;

      if (CS) chk("clk_idle_low", 32'(LCD_CLK), 32'd0);
      if (LCD_CLK && prev_clk) begin
        chk("mosi_hold_high", 32'(MOSI), 32'(prev_mosi));
        chk("dc_hold_high", 32'(DC), 32'(prev_dc));
      end

      if (cs_fall) begin
        chk("cs_high_min", 32'(hi_cnt >= int'(DIV)), 32'd1);
        last_gap = hi_cnt; low_cnt = 1; frame_rises = 0;
      end else if (!CS) begin
        low_cnt++;
      end

      if (rise) begin
        rise_total++; frame_rises++;
        if (exp_q.size() == 0) begin
          chk("unexpected_clock", 32'(rise_total), 32'd0);
        end else begin
          chk("dc_level", 32'(DC), 32'(exp_q[0][8]));
          chk("mosi_setup", 32'(mosi_stable >= int'(DIV)), 32'd1);
          if (DC !== last_rise_dc) chk("dc_setup_exact", 32'(dc_stable), 32'(DIV));
          last_rise_dc = DC;
          acc = {acc[6:0], MOSI};
          nbits++;
          if (nbits == 8) begin
            chk("byte", 32'(acc), 32'(exp_q[0][7:0]));
            last_byte = acc; bytes_rx++; nbits = 0;
            void'(exp_q.pop_front());
          end
        end
      end

      if (cs_rise) begin
        chk("frame_whole_bytes", 32'(frame_rises % 8), 32'd0);
        chk("frame_len", 32'(low_cnt), 32'(16 * int'(DIV) * (frame_rises / 8) + int'(DIV)));
        last_len = low_cnt; last_rises = frame_rises; frames_done++;
        hi_cnt = 1;
      end else if (CS) begin
        hi_cnt++;
      end

      push_pend = TX_VALID && TX_READY;
      if (push_pend) exp_q.push_back({TX_DC, TX_DATA});
      prev_cs = CS; prev_clk = LCD_CLK; prev_mosi = MOSI; prev_dc = DC; prev_busy = BUSY;
    end
  end

  task automatic push_byte(input logic dc, input logic [7:0] d);
    logic ok;
    int   n;
    n = 0;
    TX_DATA = d; TX_DC = dc; TX_VALID = 1'b1;
    forever begin
      ok = TX_READY;
      @(posedge SYSTEM_CLK); #1;
      if (ok) break;
      n++;
      if (n > 2000) begin
        chk("push_timeout", 32'(n), 32'd0);
        break;
      end
    end
    TX_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 5000) begin
      @(posedge SYSTEM_CLK); #1;
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 32'(n), 32'd0);
    repeat (3) @(posedge SYSTEM_CLK);
    #1;
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    while (rise_total < target && n < 5000) begin
      @(posedge SYSTEM_CLK); #1;
      n++;
    end
    if (n >= 5000) chk("rise_timeout", 32'(rise_total), 32'(target));
  endtask

  int fb, bb, rb, n;

  initial begin
    RST = 1'b1; TX_VALID = 1'b0; TX_DATA = '0; TX_DC = 1'b0;
    repeat (3) @(posedge SYSTEM_CLK);
    #1;
    chk("rst_cs", 32'(CS), 32'd1);
    chk("rst_lcd_clk", 32'(LCD_CLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_dc", 32'(DC), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ready", 32'(TX_READY), 32'd1);
    RST = 1'b0;
    @(posedge SYSTEM_CLK); #1;
    chk("post_rst_cs", 32'(CS), 32'd1);

    // Single command byte.
    fb = frames_done; bb = bytes_rx;
    push_byte(1'b0, 8'h2A);
    chk("cs_before_latency", 32'(CS), 32'd1);
    chk("busy_after_accept", 32'(BUSY), 32'd1);
    @(posedge SYSTEM_CLK); #1;
    chk("cs_latency", 32'(CS), 32'd0);
    chk("first_mosi", 32'(MOSI), 32'd0);
    wait_idle();
    chk("single_frames", 32'(frames_done - fb), 32'd1);
    chk("single_len", 32'(last_len), 32'd34);
    chk("single_rises", 32'(last_rises), 32'd8);
    chk("single_byte", 32'(last_byte), 32'h2A);
    chk("busy_lag", 32'(busy_lag), 32'(DIV));
    chk("single_count", 32'(bytes_rx - bb), 32'd1);

    // Back-to-back frame.
    fb = frames_done; bb = bytes_rx;
    push_byte(1'b0, 8'h2A);
    push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'h7F);
    wait_idle();
    chk("b2b_frames", 32'(frames_done - fb), 32'd1);
    chk("b2b_len", 32'(last_len), 32'd98);
    chk("b2b_rises", 32'(last_rises), 32'd24);
    chk("b2b_count", 32'(bytes_rx - bb), 32'd3);
    chk("b2b_last", 32'(last_byte), 32'h7F);

    // Backpressure with TX_VALID held.
    fb = frames_done; bb = bytes_rx; saw_full = 0;
    for (int i = 0; i < 10; i++) push_byte(1'b1, 8'(8'h10 + i));
    wait_idle();
    chk("bp_full_seen", 32'(saw_full > 0), 32'd1);
    chk("bp_frames", 32'(frames_done - fb), 32'd1);
    chk("bp_rises", 32'(last_rises), 32'd80);
    chk("bp_count", 32'(bytes_rx - bb), 32'd10);
    chk("bp_last", 32'(last_byte), 32'h19);

    // Reset during bit 3 of 0x55 with two entries queued.
    rb = rise_total;
    push_byte(1'b1, 8'h55);
    push_byte(1'(($urandom() >> 3) & 1), 8'($urandom()));
    push_byte(1'(($urandom() >> 5) & 1), 8'($urandom()));
    wait_rises(rb + 5);
    chk("mid_high_phase", 32'(LCD_CLK), 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(CS), 32'd1);
    chk("mid_rst_clk", 32'(LCD_CLK), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_ready", 32'(TX_READY), 32'd1);
    repeat (2) @(posedge SYSTEM_CLK);
    #1;
    RST = 1'b0;
    @(posedge SYSTEM_CLK); #1;
    bb = bytes_rx; fb = frames_done;
    push_byte(1'b0, 8'hA5);
    wait_idle();
    chk("after_rst_count", 32'(bytes_rx - bb), 32'd1);
    chk("after_rst_byte", 32'(last_byte), 32'hA5);
    chk("after_rst_frames", 32'(frames_done - fb), 32'd1);

    // Push landing in HOLD opens a separate frame.
    fb = frames_done; rb = rise_total;
    push_byte(1'b0, 8'h11);
    wait_rises(rb + 8);
    n = 0;
    while (LCD_CLK !== 1'b0 && n < 10) begin
      @(posedge SYSTEM_CLK); #1;
      n++;
    end
    chk("hold_cs_low", 32'(CS), 32'd0);
    push_byte(1'b1, 8'h22);
    wait_idle();
    chk("gap_frames", 32'(frames_done - fb), 32'd2);
    chk("gap_rises", 32'(last_rises), 32'd8);
    chk("gap_min", 32'(last_gap >= int'(DIV)), 32'd1);
    chk("gap_last", 32'(last_byte), 32'h22);

    // Random traffic with random idle gaps.
    bb = bytes_rx;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(40)) @(posedge SYSTEM_CLK);
      #1;
      push_byte(1'($urandom() & 1), 8'($urandom()));
    end
    wait_idle();
    chk("rand_count", 32'(bytes_rx - bb), 32'd16);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
